// File: rtl/pixel_serial_tx.sv
// pixel_serial_tx: buffers processed pixel bytes in a small FIFO and shifts
// them out MSB first, one bit per rising edge of an asynchronous host strobe
// (proc_clk). The strobe is synchronized into the clock domain and edge
// detected. Back-to-back bytes are reloaded without a gap.
module pixel_serial_tx #(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [7:0]                    s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic                          proc_clk,
  output logic                          tx_ready,
  output logic                          data_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          err_underrun
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_LOADED = 1'b1
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_push;
  logic             w_pop;
  logic             w_fifo_nonempty;
  logic [7:0]       w_rd_data;

  // Strobe synchronizer and edge detector
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_prev;
  logic                   w_synced;
  logic                   w_rise;

  // Transmit FSM and datapath
  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_shift;
  logic [7:0] w_shift_next;
  logic [2:0] r_bit_cnt;
  logic [2:0] w_bit_cnt_next;
  logic       r_err;
  logic       w_err_next;

  // NOTE: s_ready is gated by reset combinationally so the source sees "not
  // ready" for the whole reset interval, not just after the first edge.
  assign s_ready         = !reset && (r_level < LVL_W'(FIFO_DEPTH));
  assign w_push          = s_valid && s_ready;
  assign w_fifo_nonempty = (r_level != '0);
  assign w_rd_data       = r_mem[r_rd_ptr];
  assign fifo_level      = r_level;
  assign err_underrun    = r_err;

  // Write side of the FIFO storage
  // NOTE: the storage array carries no reset; only the pointers and level do,
  // so emptying on reset is exact while the RAM stays reset-free.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= s_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-2 depth)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Synchronizer chain for the asynchronous host strobe, plus edge history
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync      <= '0;
      r_sync_prev <= 1'b0;
    end else begin
      r_sync[0] <= proc_clk;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_sync_prev <= w_synced;
    end
  end

  assign w_synced = r_sync[SYNC_STAGES-1];
  assign w_rise   = w_synced && !r_sync_prev;

  // FSM state register together with shift register, bit counter and error flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_EMPTY;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_err     <= w_err_next;
    end
  end

  // Next-state logic: load, shift, reload on the last bit, or fall back to EMPTY
  always_comb begin
    // NOTE: every target gets a hold default first, so no path infers a latch.
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_cnt_next = r_bit_cnt;
    w_err_next     = r_err;
    case (r_state)
      ST_EMPTY: begin
        if (w_rise) begin
          w_err_next = 1'b1;
        end
        if (w_pop) begin
          w_shift_next   = w_rd_data;
          w_bit_cnt_next = '0;
          w_state_next   = ST_LOADED;
        end
      end
      ST_LOADED: begin
        if (w_rise) begin
          if (r_bit_cnt == 3'd7) begin
            if (w_pop) begin
              w_shift_next   = w_rd_data;
              w_bit_cnt_next = '0;
            end else begin
              w_shift_next   = '0;
              w_bit_cnt_next = '0;
              w_state_next   = ST_EMPTY;
            end
          end else begin
            w_shift_next   = {r_shift[6:0], 1'b0};
            w_bit_cnt_next = r_bit_cnt + 3'd1;
          end
        end
      end
      default: w_state_next = ST_EMPTY;
    endcase
  end

  // Output logic: status, serial bit and FIFO pop request
  always_comb begin
    tx_ready = 1'b0;
    data_out = 1'b0;
    w_pop    = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        w_pop = w_fifo_nonempty;
      end
      ST_LOADED: begin
        tx_ready = 1'b1;
        data_out = r_shift[7];
        w_pop    = w_rise && (r_bit_cnt == 3'd7) && w_fifo_nonempty;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pixel_serial_tx.sv
// Testbench for pixel_serial_tx: directed byte pushes feed a scoreboard of
// expected serial bits; a monitor pops one bit per host strobe edge and
// compares it with data_out.
module tb_pixel_serial_tx;

  localparam int FIFO_DEPTH  = 16;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = SYNC_STAGES + 2;  // strobe phase length in cycles

  logic                        clock;
  logic                        reset;
  logic [7:0]                  s_data;
  logic                        s_valid;
  logic                        s_ready;
  logic                        proc_clk;
  logic                        tx_ready;
  logic                        data_out;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic                        err_underrun;

  pixel_serial_tx #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .proc_clk    (proc_clk),
    .tx_ready    (tx_ready),
    .data_out    (data_out),
    .fifo_level  (fifo_level),
    .err_underrun(err_underrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   n_checks = 0;
  int   n_errors = 0;
  bit   exp_q[$];
  bit   mon_en   = 1'b1;
  bit   watch_gap = 1'b0;
  int   gap_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Push one byte (bounded wait on s_ready) and record its bits MSB first.
  task automatic push_byte(input logic [7:0] b);
    int budget;
    budget = 0;
    while (!s_ready && budget < 1000) begin
      tick(1);
      budget++;
    end
    if (!s_ready) begin
      check("push_ready_timeout", 32'(s_ready), 32'd1);
    end else begin
      s_data  = b;
      s_valid = 1'b1;
      for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
      tick(1);
      s_valid = 1'b0;
    end
  endtask

  // One host bit period at minimum phase timing.
  task automatic strobe();
    proc_clk = 1'b1;
    tick(HALF);
    proc_clk = 1'b0;
    tick(HALF);
  endtask

  task automatic wait_tx_ready();
    int budget;
    budget = 0;
    while (!tx_ready && budget < 1000) begin
      tick(1);
      budget++;
    end
    check("wait_tx_ready", 32'(tx_ready), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    tick(3);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_fifo_level", 32'(fifo_level), 32'd0);
    check("rst_err_underrun", 32'(err_underrun), 32'd0);
    reset = 1'b0;
    tick(2);
  endtask

  // Scoreboard monitor: the host samples data_out at each strobe rising edge.
  always @(posedge proc_clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_strobe: got strobe expected no strobe at %0t", $time);
      end else begin
        bit e;
        e = exp_q.pop_front();
        check("serial_bit", 32'(data_out), 32'(e));
        check("tx_ready_at_sample", 32'(tx_ready), 32'd1);
      end
    end
  end

  always @(posedge clock) begin
    if (watch_gap && !tx_ready) gap_cnt++;
  end

  initial begin
    #10ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    s_data   = '0;
    s_valid  = 1'b0;
    proc_clk = 1'b0;
    #1;
    do_reset();
    check("idle_s_ready", 32'(s_ready), 32'd1);

    // Single byte 0xA5
    push_byte(8'hA5);
    tick(2);
    check("a5_tx_ready", 32'(tx_ready), 32'd1);
    check("a5_first_bit", 32'(data_out), 32'd1);
    check("a5_level_after_load", 32'(fifo_level), 32'd0);
    repeat (8) strobe();
    check("a5_tx_ready_done", 32'(tx_ready), 32'd0);
    check("a5_data_out_done", 32'(data_out), 32'd0);
    check("a5_no_underrun", 32'(err_underrun), 32'd0);

    // Back-to-back bytes, no gap between them
    push_byte(8'h3C);
    push_byte(8'hFF);
    push_byte(8'h00);
    wait_tx_ready();
    gap_cnt   = 0;
    watch_gap = 1'b1;
    repeat (23) strobe();
    watch_gap = 1'b0;
    strobe();
    check("b2b_tx_ready_gap", 32'(gap_cnt), 32'd0);
    check("b2b_tx_ready_done", 32'(tx_ready), 32'd0);

    // Fill: 17 bytes, one held in the shift register and 16 queued
    for (int i = 0; i < 17; i++) push_byte(8'((i * 29 + 7) & 8'hFF));
    tick(1);
    check("full_level", 32'(fifo_level), 32'd16);
    check("full_s_ready", 32'(s_ready), 32'd0);
    check("full_tx_ready", 32'(tx_ready), 32'd1);
    repeat (8) strobe();
    check("full_level_after_byte", 32'(fifo_level), 32'd15);
    check("full_s_ready_after_byte", 32'(s_ready), 32'd1);
    repeat (16 * 8) strobe();
    check("full_drained_level", 32'(fifo_level), 32'd0);
    check("full_drained_tx_ready", 32'(tx_ready), 32'd0);

    // Underrun: strobe with nothing loaded
    mon_en = 1'b0;
    strobe();
    mon_en = 1'b1;
    check("ur_err", 32'(err_underrun), 32'd1);
    check("ur_tx_ready", 32'(tx_ready), 32'd0);
    check("ur_data_out", 32'(data_out), 32'd0);
    push_byte(8'h5A);
    wait_tx_ready();
    repeat (8) strobe();
    check("ur_err_sticky", 32'(err_underrun), 32'd1);

    // Reset in the middle of a byte discards everything queued
    push_byte(8'h81);
    push_byte(8'h7E);
    wait_tx_ready();
    repeat (3) strobe();
    do_reset();
    push_byte(8'h55);
    tick(2);
    check("mid_rst_level", 32'(fifo_level), 32'd0);
    check("mid_rst_tx_ready", 32'(tx_ready), 32'd1);
    repeat (8) strobe();
    check("mid_rst_tx_ready_done", 32'(tx_ready), 32'd0);

    // Streaming: 600 bytes pushed every 20 cycles, host at minimum timing
    fork
      begin
        for (int i = 0; i < 600; i++) begin
          push_byte(8'((i * 37 + 11) & 8'hFF));
          tick(19);
        end
      end
      begin
        wait_tx_ready();
        repeat (600 * 8) strobe();
      end
    join
    check("stream_no_underrun", 32'(err_underrun), 32'd0);
    check("stream_tx_ready_done", 32'(tx_ready), 32'd0);
    check("stream_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
